// File: rtl/pp_stream_fifo.sv
// Elastic rdy/ack stream FIFO: DEPTH-entry circular buffer with registered full/empty flags.
// Optional occupancy outputs (o_level, o_hwm) are enabled by defining PP_STREAM_FIFO_LEVEL_EN.
module pp_stream_fifo #(
    parameter int BW    = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_rdy,
    input  logic [BW-1:0] i_dat,
    output logic          o_ack,
    output logic          o_rdy,
    output logic [BW-1:0] o_dat,
`ifdef PP_STREAM_FIFO_LEVEL_EN
    output logic [AW:0]   o_level,
    output logic [AW:0]   o_hwm,
`endif
    input  logic          i_ack
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [BW-1:0] mem_reg [DEPTH];
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [AW:0]   count_reg, count_next;
    logic          full, empty, push, pop;

    // Flags come only from the registered count, so neither handshake output
    // depends combinationally on the opposite side's input.
    assign full  = (count_reg == FULL_CNT);
    assign empty = (count_reg == '0);
    assign o_ack = i_rdy & ~full;
    assign o_rdy = ~empty;
    assign o_dat = mem_reg[rd_ptr_reg];
    assign push  = i_rdy & o_ack;
    assign pop   = o_rdy & i_ack;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage words are never reset; each one loads only when the write pointer selects it.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge clk) begin
                if (!rst && push && (wr_ptr_reg == AW'(gi))) begin
                    mem_reg[gi] <= i_dat;
                end
            end
        end
    endgenerate

`ifdef PP_STREAM_FIFO_LEVEL_EN
    logic [AW:0] hwm_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            hwm_reg <= '0;
        end else if (count_reg > hwm_reg) begin
            hwm_reg <= count_reg;
        end
    end

    assign o_level = count_reg;
    assign o_hwm   = hwm_reg;
`endif

endmodule
